// File: rtl/axi4s_uart_cfg.sv
// UART with an elaboration-time frame format (5..8 data bits, none/even/odd parity, 1 or 2 stops)
// bridging AXI4-Stream byte channels; RX reports parity/framing errors on tuser and pulses overrun.
module axi4s_uart_cfg #(
  parameter int ACLK_FREQUENCY = 200000000,
  parameter int BAUD_RATE      = 9600,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic       aclk,
  input  logic       aresetn,
  output logic       uart_txd,
  input  logic       uart_rxd,
  input  logic       tx_byte_tvalid,
  output logic       tx_byte_tready,
  input  logic [7:0] tx_byte_tdata,
  input  logic       tx_byte_tkeep,
  output logic       rx_byte_tvalid,
  input  logic       rx_byte_tready,
  output logic [7:0] rx_byte_tdata,
  output logic [1:0] rx_byte_tuser,
  output logic       rx_overrun
);

  localparam int CLKS_PER_BIT = ACLK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 2);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_clks
      $error("axi4s_uart_cfg: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
      $error("axi4s_uart_cfg: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("axi4s_uart_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("axi4s_uart_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  // ---------------- transmitter ----------------
  state_t               tx_state_reg;
  logic [CNT_W-1:0]     tx_cnt_reg;
  logic [2:0]           tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg;
  logic                 txd_reg;
  logic                 tx_ready_reg;

  assign uart_txd       = txd_reg;
  assign tx_byte_tready = tx_ready_reg;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tx_state_reg <= S_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      txd_reg      <= 1'b1;
      tx_ready_reg <= 1'b1;
    end else begin
      case (tx_state_reg)
        S_IDLE: begin
          // tkeep=0 beats are accepted here and simply dropped
          if (tx_byte_tvalid && tx_byte_tkeep) begin
            tx_shift_reg <= tx_byte_tdata[DATA_BITS-1:0];
            tx_par_reg   <= (^tx_byte_tdata[DATA_BITS-1:0]) ^ PAR_ODD;
            tx_cnt_reg   <= '0;
            txd_reg      <= 1'b0;
            tx_ready_reg <= 1'b0;
            tx_state_reg <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            txd_reg      <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_state_reg <= S_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
          end
        end
        S_DATA: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == DATA_LAST) begin
              tx_bit_reg <= '0;
              if (PARITY != 0) begin
                txd_reg      <= tx_par_reg;
                tx_state_reg <= S_PARITY;
              end else begin
                txd_reg      <= 1'b1;
                tx_state_reg <= S_STOP;
              end
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              txd_reg      <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
          end
        end
        S_PARITY: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            txd_reg      <= 1'b1;
            tx_state_reg <= S_STOP;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
          end
        end
        S_STOP: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == STOP_LAST) begin
              tx_bit_reg   <= '0;
              tx_ready_reg <= 1'b1;
              tx_state_reg <= S_IDLE;
            end else begin
              tx_bit_reg <= tx_bit_reg + 3'd1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
          end
        end
        default: begin
          txd_reg      <= 1'b1;
          tx_ready_reg <= 1'b1;
          tx_state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  state_t               rx_state_reg;
  logic [CNT_W-1:0]     rx_cnt_reg;
  logic [2:0]           rx_bit_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 rx_par_reg;
  logic                 rxd_meta_reg;
  logic                 rxd_sync_reg;
  logic                 rx_valid_reg;
  logic [7:0]           rx_data_reg;
  logic [1:0]           rx_user_reg;
  logic                 rx_ovr_reg;
  logic                 rx_par_err;
  logic [7:0]           rx_data_ext;

  assign rx_byte_tvalid = rx_valid_reg;
  assign rx_byte_tdata  = rx_data_reg;
  assign rx_byte_tuser  = rx_user_reg;
  assign rx_overrun     = rx_ovr_reg;

  always_comb begin
    rx_data_ext                  = '0;
    rx_data_ext[DATA_BITS-1:0]   = rx_shift_reg;
    rx_par_err = (PARITY != 0) && (rx_par_reg != ((^rx_shift_reg) ^ PAR_ODD));
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rx_state_reg <= S_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_par_reg   <= 1'b0;
      rx_valid_reg <= 1'b0;
      rx_data_reg  <= '0;
      rx_user_reg  <= '0;
      rx_ovr_reg   <= 1'b0;
    end else begin
      rxd_meta_reg <= uart_rxd;
      rxd_sync_reg <= rxd_meta_reg;
      rx_ovr_reg   <= 1'b0;
      if (rx_valid_reg && rx_byte_tready) begin
        rx_valid_reg <= 1'b0;
      end
      case (rx_state_reg)
        S_IDLE: begin
          if (!rxd_sync_reg) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_reg == BIT_HALF) begin
            rx_cnt_reg <= '0;
            rx_bit_reg <= '0;
            rx_state_reg <= rxd_sync_reg ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
        S_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rxd_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_bit_reg == DATA_LAST) begin
              rx_state_reg <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              rx_bit_reg <= rx_bit_reg + 3'd1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
        S_PARITY: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_par_reg   <= rxd_sync_reg;
            rx_state_reg <= S_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
        S_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg <= '0;
            // a slot freed by a same-cycle handshake can take the new byte
            if (!rx_valid_reg || rx_byte_tready) begin
              rx_data_reg  <= rx_data_ext;
              rx_user_reg  <= {~rxd_sync_reg, rx_par_err};
              rx_valid_reg <= 1'b1;
            end else begin
              rx_ovr_reg <= 1'b1;
            end
            rx_state_reg <= rxd_sync_reg ? S_IDLE : S_BREAK;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
        S_BREAK: begin
          if (rxd_sync_reg) begin
            rx_state_reg <= S_IDLE;
          end
        end
        default: rx_state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4s_uart_cfg.sv
// Directed bench for axi4s_uart_cfg: 8N1 (A), 7E2 loopback (B) and 8O1 (C) instances at 10 clocks per bit.
module tb_axi4s_uart_cfg;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int ovr_cnt_a   = 0;

  logic a_txd, a_rxd, a_tx_valid, a_tx_ready, a_tx_keep, a_rx_valid, a_rx_ready, a_ovr;
  logic [7:0] a_tx_data, a_rx_data;
  logic [1:0] a_rx_user;
  logic b_txd, b_tx_valid, b_tx_ready, b_tx_keep, b_rx_valid, b_rx_ready, b_ovr;
  logic [7:0] b_tx_data, b_rx_data;
  logic [1:0] b_rx_user;
  logic c_txd, c_rxd, c_tx_valid, c_tx_ready, c_tx_keep, c_rx_valid, c_rx_ready, c_ovr;
  logic [7:0] c_tx_data, c_rx_data;
  logic [1:0] c_rx_user;

  axi4s_uart_cfg #(.ACLK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .aclk(clk), .aresetn(aresetn), .uart_txd(a_txd), .uart_rxd(a_rxd),
    .tx_byte_tvalid(a_tx_valid), .tx_byte_tready(a_tx_ready), .tx_byte_tdata(a_tx_data), .tx_byte_tkeep(a_tx_keep),
    .rx_byte_tvalid(a_rx_valid), .rx_byte_tready(a_rx_ready), .rx_byte_tdata(a_rx_data), .rx_byte_tuser(a_rx_user),
    .rx_overrun(a_ovr));

  axi4s_uart_cfg #(.ACLK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_b (
    .aclk(clk), .aresetn(aresetn), .uart_txd(b_txd), .uart_rxd(b_txd),
    .tx_byte_tvalid(b_tx_valid), .tx_byte_tready(b_tx_ready), .tx_byte_tdata(b_tx_data), .tx_byte_tkeep(b_tx_keep),
    .rx_byte_tvalid(b_rx_valid), .rx_byte_tready(b_rx_ready), .rx_byte_tdata(b_rx_data), .rx_byte_tuser(b_rx_user),
    .rx_overrun(b_ovr));

  axi4s_uart_cfg #(.ACLK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_c (
    .aclk(clk), .aresetn(aresetn), .uart_txd(c_txd), .uart_rxd(c_rxd),
    .tx_byte_tvalid(c_tx_valid), .tx_byte_tready(c_tx_ready), .tx_byte_tdata(c_tx_data), .tx_byte_tkeep(c_tx_keep),
    .rx_byte_tvalid(c_rx_valid), .rx_byte_tready(c_rx_ready), .rx_byte_tdata(c_rx_data), .rx_byte_tuser(c_rx_user),
    .rx_overrun(c_ovr));

  always @(negedge clk) begin
    if (a_ovr === 1'b1) ovr_cnt_a++;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives a frame on A's or C's rxd, bits[0] first, 10 cycles per bit
  task automatic drive_frame(input bit to_c, input int nbits, input logic [15:0] bits);
    for (int j = 0; j < nbits; j++) begin
      if (to_c) c_rxd = bits[j];
      else      a_rxd = bits[j];
      repeat (10) @(negedge clk);
    end
  endtask

  // 7E2 loopback frame on B: checks start, parity and stop on txd, then the looped-back byte
  task automatic b_frame(input logic [7:0] d, input logic par);
    chk("b_tready_idle", b_tx_ready, 1);
    b_tx_valid = 1'b1; b_tx_data = d; b_tx_keep = 1'b1;
    @(negedge clk);
    b_tx_valid = 1'b0;
    for (int k = 0; k < 110; k++) begin
      if (k == 5)   chk("b_start_bit", b_txd, 0);
      if (k == 85)  chk("b_parity_bit", b_txd, par);
      if (k == 105) begin
        chk("b_stop2_bit", b_txd, 1);
        chk("b_rx_valid", b_rx_valid, 1);
        chk("b_rx_data", b_rx_data, d);
        chk("b_rx_user", b_rx_user, 0);
        b_rx_ready = 1'b1;
      end
      if (k == 106) begin
        b_rx_ready = 1'b0;
        chk("b_rx_valid_clr", b_rx_valid, 0);
      end
      if (k == 109) chk("b_tready_busy", b_tx_ready, 0);
      @(negedge clk);
    end
    chk("b_tready_back", b_tx_ready, 1);
  endtask

  logic [9:0] a5_bits;

  initial begin
    aresetn = 1'b0;
    a_rxd = 1'b1; a_tx_valid = 1'b0; a_tx_data = '0; a_tx_keep = 1'b1; a_rx_ready = 1'b0;
    b_tx_valid = 1'b0; b_tx_data = '0; b_tx_keep = 1'b1; b_rx_ready = 1'b0;
    c_rxd = 1'b1; c_tx_valid = 1'b0; c_tx_data = '0; c_tx_keep = 1'b1; c_rx_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_txd", a_txd, 1);
    chk("rst_tready", a_tx_ready, 1);
    chk("rst_rx_valid", a_rx_valid, 0);
    chk("rst_rx_data", a_rx_data, 0);
    chk("rst_rx_user", a_rx_user, 0);
    chk("rst_overrun", a_ovr, 0);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1 TX of 0xA5
    a5_bits = 10'b1_10100101_0;
    chk("a_tready_pre", a_tx_ready, 1);
    a_tx_valid = 1'b1; a_tx_data = 8'hA5; a_tx_keep = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      chk("a_txd_bit", a_txd, a5_bits[k / 10]);
      chk("a_tready_busy", a_tx_ready, 0);
      @(negedge clk);
    end
    chk("a_tready_back", a_tx_ready, 1);
    chk("a_txd_idle", a_txd, 1);

    // tkeep=0 beat is swallowed in one cycle without a frame
    a_tx_valid = 1'b1; a_tx_data = 8'hFF; a_tx_keep = 1'b0;
    chk("a_keep0_ready", a_tx_ready, 1);
    @(negedge clk);
    a_tx_valid = 1'b0; a_tx_keep = 1'b1;
    chk("a_keep0_ready_after", a_tx_ready, 1);
    for (int k = 0; k < 20; k++) begin
      chk("a_keep0_txd", a_txd, 1);
      @(negedge clk);
    end

    // 8N1 RX overrun: second frame dropped while the first is still held
    drive_frame(1'b0, 10, {6'b0, 1'b1, 8'h11, 1'b0});
    repeat (2) @(negedge clk);
    chk("a_rx_valid1", a_rx_valid, 1);
    chk("a_rx_data1", a_rx_data, 8'h11);
    chk("a_rx_user1", a_rx_user, 0);
    chk("a_ovr_none", ovr_cnt_a, 0);
    drive_frame(1'b0, 10, {6'b0, 1'b1, 8'h22, 1'b0});
    repeat (2) @(negedge clk);
    chk("a_ovr_once", ovr_cnt_a, 1);
    chk("a_rx_hold_valid", a_rx_valid, 1);
    chk("a_rx_hold_data", a_rx_data, 8'h11);
    a_rx_ready = 1'b1;
    @(negedge clk);
    a_rx_ready = 1'b0;
    chk("a_rx_valid_clr", a_rx_valid, 0);

    // 7E2 loopback
    b_frame(8'h53, 1'b0);
    b_frame(8'h7F, 1'b1);

    // 8O1 RX: bad parity, then a zero stop bit held low as a break
    drive_frame(1'b1, 11, {5'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    repeat (2) @(negedge clk);
    chk("c_par_valid", c_rx_valid, 1);
    chk("c_par_data", c_rx_data, 8'h00);
    chk("c_par_user", c_rx_user, 2'b01);
    c_rx_ready = 1'b1; @(negedge clk); c_rx_ready = 1'b0;
    chk("c_par_clr", c_rx_valid, 0);

    drive_frame(1'b1, 11, {5'b0, 1'b0, 1'b1, 8'h00, 1'b0});
    repeat (2) @(negedge clk);
    chk("c_frm_valid", c_rx_valid, 1);
    chk("c_frm_data", c_rx_data, 8'h00);
    chk("c_frm_user", c_rx_user, 2'b10);
    c_rx_ready = 1'b1; @(negedge clk); c_rx_ready = 1'b0;
    repeat (150) @(negedge clk);
    chk("c_break_quiet", c_rx_valid, 0);
    c_rxd = 1'b1;
    repeat (20) @(negedge clk);

    // 3-cycle glitch must be rejected as a false start
    c_rxd = 1'b0;
    repeat (3) @(negedge clk);
    c_rxd = 1'b1;
    repeat (150) @(negedge clk);
    chk("c_glitch_quiet", c_rx_valid, 0);
    drive_frame(1'b1, 11, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0});
    repeat (2) @(negedge clk);
    chk("c_3c_valid", c_rx_valid, 1);
    chk("c_3c_data", c_rx_data, 8'h3C);
    chk("c_3c_user", c_rx_user, 2'b00);
    c_rx_ready = 1'b1; @(negedge clk); c_rx_ready = 1'b0;

    // reset in the middle of a B loopback frame
    b_tx_valid = 1'b1; b_tx_data = 8'h53; b_tx_keep = 1'b1;
    @(negedge clk);
    b_tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("b_mid_txd_busy", b_tx_ready, 0);
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    chk("b_rst_txd", b_txd, 1);
    chk("b_rst_tready", b_tx_ready, 1);
    chk("b_rst_rx_valid", b_rx_valid, 0);
    repeat (150) @(negedge clk);
    chk("b_rst_no_partial", b_rx_valid, 0);
    b_frame(8'h7F, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
